hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and branch controller for the 16-bit, 8-register, 5-stage core. It decodes the instruction held in the IF/ID register and tracks the destinations of the instructions in EX and MEM. From these it drives `stall` to IF and ID, inserts bubbles into EX, and qualifies branches resolved in ID into `branch_taken`, `branch_offset_imm` and `if_flush`. It also keeps saturating stall and flush event counters for debug.

## Interface
- `FORWARDING`, default 0: 0 = no bypass network, so stall on any RAW against EX or MEM; 1 = bypass present, so stall only on load-use against EX.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `id_instr`  in  16  instruction currently in the IF/ID register; 16'h0000 = NOP.
- `branch_cond`  in  1  ID-stage compare result: source register == 0.
- `stall`  out  1  hold PC and IF/ID.
- `ex_bubble`  out  1  load NOP into ID/EX this cycle.
- `if_flush`  out  1  load NOP into IF/ID this cycle.
- `branch_taken`  out  1  to IF `branch_taken`.
- `branch_offset_imm`  out  6  to IF, equal to `id_instr[5:0]`.
- `stall_cnt`  out  16  stall cycles, saturating.
- `flush_cnt`  out  16  taken branches, saturating.

## Operation
- Field layout: opcode [15:12], A [11:9], B [8:6], C [5:3], imm [5:0].
- Opcode map:
  - 0: NOP.
  - 1–7: ADD, SUB, AND, OR, XOR, SL, SR.
  - 9: ADDI.
  - 10: LD.
  - 11: ST.
  - 12: BR.
  - All other opcodes are treated as NOP.
- Sources:
  - R-type: B and C.
  - ADDI and LD: B.
  - ST: B and A.
  - BR: B.
- Destination:
  - R-type, ADDI and LD write A.
  - A = 0 means no destination, because R0 is hardwired to zero.
  - All other opcodes have no destination.
- Scoreboard:
  - Two entries, EX and MEM; each holds {valid, dst[2:0], is_load}.
  - Every cycle, MEM ← EX.
  - EX ← decoded ID instruction, or an invalid entry when `stall`=1.
- The register file writes before it reads, so WB is never a hazard source.
- Hazard condition with `FORWARDING`=0: any valid source equals the dst of a valid EX or MEM entry.
- Hazard condition with `FORWARDING`=1: any valid source equals the dst of a valid EX entry with is_load=1.
- `stall` = hazard. `ex_bubble` = `stall`.
- Branch qualification:
  - `branch_taken` = (opcode==BR) & `branch_cond` & !`stall`.
  - `if_flush` = `branch_taken`.
  - A stalled branch is re-evaluated once the stall clears.
- BR and ST enter the scoreboard as non-writers (valid=0).
- Counters:
  - `stall_cnt` increments on every cycle with `stall`=1.
  - `flush_cnt` increments on every cycle with `branch_taken`=1.
  - Both hold at 16'hFFFF once reached.

## Timing
- `stall`, `ex_bubble`, `if_flush`, `branch_taken` and `branch_offset_imm` are combinational from `id_instr`, `branch_cond` and scoreboard state, and take effect at the same clock edge.
- The scoreboard and counters update on the rising edge of `clk`.
- Reset:
  - Both scoreboard entries become invalid and both counters become 0.
  - While `id_instr`=0, every output is 0 during and after reset.
- Stall lengths with `FORWARDING`=0:
  - Dependency on EX: 2 stall cycles.
  - Dependency on MEM: 1 stall cycle.
- Stall length with `FORWARDING`=1: load-use costs exactly 1 stall cycle.
- Branch timing:
  - On a taken branch, the instruction fetched that cycle is squashed.
  - The next cycle, ID holds a NOP, and the branch target is fetched that same cycle.
- Reset mid-stall: `stall` drops in the same cycle that `rst` asserts, and no counter increments while `rst` is high.
- Simultaneous hazard and branch: `stall` wins; `branch_taken`=0 and `if_flush`=0.

## Structure
- Shared package `cpu_pkg`:
  - Opcode constants (OP_NOP … OP_BR).
  - Field bit positions.
  - Scoreboard entry struct.
- Sub-module `instr_decode`: combinational; produces src_b_v, src_c_v, src_a_v, dst_v, dst, is_load and is_br from the 16-bit instruction.
- Top level: scoreboard registers, hazard compare, branch qualification, counters.

## Test plan
- Case 1, `FORWARDING`=0, RAW on EX:
  - Stimulus: 16'h9205 (ADDI r1=5), then 16'h9641 (ADDI r3=r1+1).
  - Response: `stall`=1 for 2 cycles, `ex_bubble`=1 for 2 cycles, `stall_cnt`=2.
- Case 2, `FORWARDING`=1, load-use:
  - Stimulus: 16'hAECE (LD r7), then 16'h17B8 (ADD r3=r6+r7).
  - Response: `stall`=1 for exactly 1 cycle.
  - Same sequence with `FORWARDING`=0 gives 2 stall cycles.
- Case 3, branch taken:
  - Stimulus: 16'hC041 (BR r1,+1) with `branch_cond`=1 and no hazard.
  - Response: `branch_taken`=1, `if_flush`=1, `branch_offset_imm`=6'b000001, `flush_cnt`=1.
  - With `branch_cond`=0, all three outputs are 0.
- Case 4, R0 destination:
  - Stimulus: 16'h11C0 (ADD r0=r7+r0), then 16'h9001 (ADDI r0=r0+1).
  - Response: `stall` stays 0.
- Case 5, branch behind hazard:
  - Stimulus: 16'h9205, then 16'hC041 with `branch_cond`=1, `FORWARDING`=0.
  - Response: `branch_taken`=0 for 2 cycles, then 1 for one cycle.
- Case 6, reset and saturation:
  - Stimulus: assert `rst` during a stall.
  - Response: `stall`=0 at once, counters read 0, and the scoreboard is empty after release.
  - Separately, force 65536+ stall cycles: `stall_cnt` holds at 16'hFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the 16-bit, 8-register, 5-stage core:
//                opcode constants, instruction field positions and the
//                hazard scoreboard entry type.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Opcodes; every value not listed decodes as NOP.
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SL   = 4'd6;
    localparam logic [3:0] OP_SR   = 4'd7;
    localparam logic [3:0] OP_ADDI = 4'd9;
    localparam logic [3:0] OP_LD   = 4'd10;
    localparam logic [3:0] OP_ST   = 4'd11;
    localparam logic [3:0] OP_BR   = 4'd12;

    // Field bit positions.
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int FA_HI  = 11;
    localparam int FA_LO  = 9;
    localparam int FB_HI  = 8;
    localparam int FB_LO  = 6;
    localparam int FC_HI  = 5;
    localparam int FC_LO  = 3;
    localparam int IMM_HI = 5;
    localparam int IMM_LO = 0;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic       valid;    // instruction writes a register (never R0)
        logic [2:0] dst;
        logic       is_load;
    } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decode
//  Description : Combinational decode of the IF/ID instruction into register
//                source/destination usage for hazard detection.
//  Ports       : i_instr            - instruction word
//                o_src_{a,b,c}      - source register numbers
//                o_src_{a,b,c}_v    - corresponding source is read
//                o_dst / o_dst_v    - destination register, valid if written
//                o_is_load, o_is_br - LD / BR indicators
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_decode
    import cpu_pkg::*;
(
    input  logic [15:0] i_instr,
    output logic [2:0]  o_src_a,
    output logic [2:0]  o_src_b,
    output logic [2:0]  o_src_c,
    output logic        o_src_a_v,
    output logic        o_src_b_v,
    output logic        o_src_c_v,
    output logic [2:0]  o_dst,
    output logic        o_dst_v,
    output logic        o_is_load,
    output logic        o_is_br
);

    logic [3:0] w_op;
    logic       w_rtype;
    logic       w_addi;
    logic       w_ld;
    logic       w_st;
    logic       w_br;
    logic       w_unused_low;

    assign w_op    = i_instr[OPC_HI:OPC_LO];
    assign o_src_a = i_instr[FA_HI:FA_LO];
    assign o_src_b = i_instr[FB_HI:FB_LO];
    assign o_src_c = i_instr[FC_HI:FC_LO];
    assign o_dst   = i_instr[FA_HI:FA_LO];

    // Low immediate bits never name a register.
    assign w_unused_low = ^i_instr[2:0];

    assign w_rtype = (w_op >= OP_ADD) && (w_op <= OP_SR);
    assign w_addi  = (w_op == OP_ADDI);
    assign w_ld    = (w_op == OP_LD);
    assign w_st    = (w_op == OP_ST);
    assign w_br    = (w_op == OP_BR);

    assign o_src_b_v = w_rtype | w_addi | w_ld | w_st | w_br;
    assign o_src_c_v = w_rtype;
    assign o_src_a_v = w_st;                 // ST reads its data register from A
    // R0 is hardwired to zero, so writing it creates no dependency.
    assign o_dst_v   = (w_rtype | w_addi | w_ld) && (o_dst != 3'd0);
    assign o_is_load = w_ld;
    assign o_is_br   = w_br;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard and branch controller. Tracks destinations of
//                the EX and MEM instructions, stalls IF/ID on RAW hazards,
//                qualifies ID-stage branches, and counts stall/flush events.
//  Params      : FORWARDING - 0: stall on any RAW vs EX/MEM
//                             1: stall only on load-use vs EX
//  Ports       : clk, rst (async, active-high)
//                i_id_instr, i_branch_cond       - ID-stage inputs
//                o_stall, o_ex_bubble            - hold IF/ID, bubble ID/EX
//                o_if_flush, o_branch_taken,
//                o_branch_offset_imm             - branch redirect to IF
//                o_stall_cnt, o_flush_cnt        - saturating debug counters
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter bit FORWARDING = 1'b0
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_id_instr,
    input  logic        i_branch_cond,
    output logic        o_stall,
    output logic        o_ex_bubble,
    output logic        o_if_flush,
    output logic        o_branch_taken,
    output logic [5:0]  o_branch_offset_imm,
    output logic [15:0] o_stall_cnt,
    output logic [15:0] o_flush_cnt
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [2:0] w_src_a, w_src_b, w_src_c, w_dst;
    logic       w_src_a_v, w_src_b_v, w_src_c_v, w_dst_v;
    logic       w_is_load, w_is_br;

    sb_entry_t  r_ex;
    sb_entry_t  r_mem;
    sb_entry_t  w_id_entry;

    logic       w_ex_match, w_mem_match;
    logic       w_ex_hit, w_mem_hit;
    logic       w_stall;
    logic       w_taken;

    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    instr_decode u_decode (
        .i_instr   (i_id_instr),
        .o_src_a   (w_src_a),
        .o_src_b   (w_src_b),
        .o_src_c   (w_src_c),
        .o_src_a_v (w_src_a_v),
        .o_src_b_v (w_src_b_v),
        .o_src_c_v (w_src_c_v),
        .o_dst     (w_dst),
        .o_dst_v   (w_dst_v),
        .o_is_load (w_is_load),
        .o_is_br   (w_is_br)
    );

    assign w_id_entry = '{valid: w_dst_v, dst: w_dst, is_load: w_is_load};

    // Does any source read by the ID instruction name the entry's destination?
    always_comb begin
        w_ex_match  = (w_src_a_v && (w_src_a == r_ex.dst))
                   || (w_src_b_v && (w_src_b == r_ex.dst))
                   || (w_src_c_v && (w_src_c == r_ex.dst));
        w_mem_match = (w_src_a_v && (w_src_a == r_mem.dst))
                   || (w_src_b_v && (w_src_b == r_mem.dst))
                   || (w_src_c_v && (w_src_c == r_mem.dst));
    end

    // With the bypass network only a load in EX is still unresolved in time.
    assign w_ex_hit  = r_ex.valid && w_ex_match
                    && ((FORWARDING == 1'b0) || r_ex.is_load);
    assign w_mem_hit = (FORWARDING == 1'b0) && r_mem.valid && w_mem_match;
    assign w_stall   = w_ex_hit || w_mem_hit;

    // A stalled branch is simply re-presented next cycle and re-qualified.
    assign w_taken = w_is_br && i_branch_cond && !w_stall;

    assign o_stall             = w_stall;
    assign o_ex_bubble         = w_stall;
    assign o_branch_taken      = w_taken;
    assign o_if_flush          = w_taken;
    assign o_branch_offset_imm = i_id_instr[IMM_HI:IMM_LO];
    assign o_stall_cnt         = r_stall_cnt;
    assign o_flush_cnt         = r_flush_cnt;

    // Scoreboard: the instruction held in ID does not advance while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex  <= '0;
            r_mem <= '0;
        end else begin
            r_mem <= r_ex;
            r_ex  <= w_stall ? '0 : w_id_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (w_stall && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_taken && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl. Two instances (without
//                and with forwarding) share stimulus: a directed vector table,
//                randomized traffic against a reference model, and
//                hand-written reset / counter-saturation sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] id_instr;
    logic        branch_cond;

    logic [1:0]  st, eb, fl, bt;
    logic [5:0]  imm [2];
    logic [15:0] sc  [2];
    logic [15:0] fc  [2];

    int total;
    int bad;

    hazard_ctrl #(.FORWARDING(1'b0)) dut0 (
        .clk                 (clk),
        .rst                 (rst),
        .i_id_instr          (id_instr),
        .i_branch_cond       (branch_cond),
        .o_stall             (st[0]),
        .o_ex_bubble         (eb[0]),
        .o_if_flush          (fl[0]),
        .o_branch_taken      (bt[0]),
        .o_branch_offset_imm (imm[0]),
        .o_stall_cnt         (sc[0]),
        .o_flush_cnt         (fc[0])
    );

    hazard_ctrl #(.FORWARDING(1'b1)) dut1 (
        .clk                 (clk),
        .rst                 (rst),
        .i_id_instr          (id_instr),
        .i_branch_cond       (branch_cond),
        .o_stall             (st[1]),
        .o_ex_bubble         (eb[1]),
        .o_if_flush          (fl[1]),
        .o_branch_taken      (bt[1]),
        .o_branch_offset_imm (imm[1]),
        .o_stall_cnt         (sc[1]),
        .o_flush_cnt         (fc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0d: got=%0h want=%0h", nm, idx, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each DUT flavour keeps the two most recently issued instructions
    // (age 0 = one cycle ago, age 1 = two cycles ago) as register numbers,
    // -1 meaning "writes nothing".
    int m_dst [2][2];
    bit m_ld  [2][2];
    int m_sc  [2];
    int m_fc  [2];

    function automatic void ref_decode(input logic [15:0] ins, output bit [7:0] rd,
                                       output int dst, output bit ld, output bit br);
        int op, a, b, c;
        op = int'(ins[15:12]);
        a  = int'(ins[11:9]);
        b  = int'(ins[8:6]);
        c  = int'(ins[5:3]);
        rd = 8'h00; dst = -1; ld = 1'b0; br = 1'b0;
        if (op >= 1 && op <= 7) begin rd[b] = 1'b1; rd[c] = 1'b1; dst = a; end
        else if (op == 9)       begin rd[b] = 1'b1; dst = a; end
        else if (op == 10)      begin rd[b] = 1'b1; dst = a; ld = 1'b1; end
        else if (op == 11)      begin rd[b] = 1'b1; rd[a] = 1'b1; end
        else if (op == 12)      begin rd[b] = 1'b1; br = 1'b1; end
        if (dst == 0) dst = -1;
    endfunction

    function automatic bit ref_hazard(input int f, input bit [7:0] rd);
        bit h;
        h = 1'b0;
        for (int age = 0; age < 2; age++) begin
            if (m_dst[f][age] >= 0 && rd[m_dst[f][age]]) begin
                if (f == 0) h = 1'b1;                           // no bypass: any in-flight writer
                else if (age == 0 && m_ld[f][age]) h = 1'b1;    // bypass: only load-use from EX
            end
        end
        return h;
    endfunction

    task automatic ref_reset();
        for (int f = 0; f < 2; f++) begin
            m_sc[f] = 0; m_fc[f] = 0;
            for (int a = 0; a < 2; a++) begin m_dst[f][a] = -1; m_ld[f][a] = 1'b0; end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [15:0] instr;
        logic        cond;
        logic        s0, s1;   // expected stall without / with forwarding
        logic        b0, b1;   // expected branch_taken
    } vec_t;

    localparam int NV = 24;
    vec_t tbl [NV];

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1; id_instr = 16'h0000; branch_cond = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int es [2];
        int ef [2];
        bit [7:0] rd;
        int dst;
        bit ld, br, hz;
        bit [1:0] ehz, ebt;
        logic [15:0] ins;

        total = 0; bad = 0;
        rst = 1'b1; id_instr = 16'h0000; branch_cond = 1'b0;

        // Case 1: RAW on EX
        tbl[0]  = '{16'h9205, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{16'h9641, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{16'h9641, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{16'h9641, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        // Case 2: load-use
        tbl[6]  = '{16'hAECE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{16'h17B8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{16'h17B8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{16'h17B8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        // Case 3: branch taken / not taken
        tbl[12] = '{16'hC041, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{16'hC041, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        // Case 4: R0 destination never creates a hazard
        tbl[16] = '{16'h11C0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{16'h9001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        // Case 5: branch behind a hazard
        tbl[19] = '{16'h9205, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[20] = '{16'hC041, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[21] = '{16'hC041, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[22] = '{16'hC041, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[23] = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state, sampled while reset is held
        @(negedge clk);
        @(negedge clk);
        for (int f = 0; f < 2; f++) begin
            chk("rst_stall", f, 32'(st[f]), 32'd0);
            chk("rst_bubble", f, 32'(eb[f]), 32'd0);
            chk("rst_flush", f, 32'(fl[f]), 32'd0);
            chk("rst_taken", f, 32'(bt[f]), 32'd0);
            chk("rst_imm", f, 32'(imm[f]), 32'd0);
            chk("rst_scnt", f, 32'(sc[f]), 32'd0);
            chk("rst_fcnt", f, 32'(fc[f]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // ---- table ----
        es[0] = 0; es[1] = 0; ef[0] = 0; ef[1] = 0;
        for (int i = 0; i < NV; i++) begin
            id_instr    = tbl[i].instr;
            branch_cond = tbl[i].cond;
            ehz = {tbl[i].s1, tbl[i].s0};
            ebt = {tbl[i].b1, tbl[i].b0};
            @(negedge clk);
            for (int f = 0; f < 2; f++) begin
                chk("tbl_stall", i * 2 + f, 32'(st[f]), 32'(ehz[f]));
                chk("tbl_bubble", i * 2 + f, 32'(eb[f]), 32'(ehz[f]));
                chk("tbl_taken", i * 2 + f, 32'(bt[f]), 32'(ebt[f]));
                chk("tbl_flush", i * 2 + f, 32'(fl[f]), 32'(ebt[f]));
                chk("tbl_imm", i * 2 + f, 32'(imm[f]), 32'(tbl[i].instr[5:0]));
                chk("tbl_scnt", i * 2 + f, 32'(sc[f]), 32'(es[f]));
                chk("tbl_fcnt", i * 2 + f, 32'(fc[f]), 32'(ef[f]));
                es[f] += int'(ehz[f]);
                ef[f] += int'(ebt[f]);
            end
            @(posedge clk); #1;
        end
        // Totals from the test plan: no-forwarding stalls 2+2+2, flushes 2
        @(negedge clk);
        chk("tbl_end_scnt0", 0, 32'(sc[0]), 32'd6);
        chk("tbl_end_fcnt0", 0, 32'(fc[0]), 32'd2);
        chk("tbl_end_scnt1", 1, 32'(sc[1]), 32'd1);
        chk("tbl_end_fcnt1", 1, 32'(fc[1]), 32'd4);

        // ---- randomized traffic vs reference model ----
        pulse_reset();
        ref_reset();
        for (int n = 0; n < 1500; n++) begin
            ins = {4'($urandom_range(0, 15)), 3'($urandom_range(0, 3)),
                   3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                   3'($urandom_range(0, 7))};
            id_instr    = ins;
            branch_cond = 1'($urandom_range(0, 1));
            ref_decode(ins, rd, dst, ld, br);
            @(negedge clk);
            for (int f = 0; f < 2; f++) begin
                hz = ref_hazard(f, rd);
                chk("rnd_stall", n, 32'(st[f]), 32'(hz));
                chk("rnd_bubble", n, 32'(eb[f]), 32'(hz));
                chk("rnd_taken", n, 32'(bt[f]), 32'(br && branch_cond && !hz));
                chk("rnd_flush", n, 32'(fl[f]), 32'(br && branch_cond && !hz));
                chk("rnd_imm", n, 32'(imm[f]), 32'(ins[5:0]));
                chk("rnd_scnt", n, 32'(sc[f]), 32'(m_sc[f]));
                chk("rnd_fcnt", n, 32'(fc[f]), 32'(m_fc[f]));
                if (hz && m_sc[f] < 65535) m_sc[f]++;
                if (br && branch_cond && !hz && m_fc[f] < 65535) m_fc[f]++;
                m_dst[f][1] = m_dst[f][0];
                m_ld[f][1]  = m_ld[f][0];
                m_dst[f][0] = hz ? -1 : dst;
                m_ld[f][0]  = hz ? 1'b0 : ld;
            end
            @(posedge clk); #1;
        end

        // ---- reset asserted in the middle of a stall ----
        id_instr = 16'h9205; branch_cond = 1'b0;
        @(posedge clk); #1;
        id_instr = 16'h9241;                     // ADDI r1 = r1 + 1
        @(negedge clk);
        chk("midrst_pre_stall", 0, 32'(st[0]), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_stall", 0, 32'(st[0]), 32'd0);
        chk("midrst_bubble", 0, 32'(eb[0]), 32'd0);
        chk("midrst_scnt0", 0, 32'(sc[0]), 32'd0);
        chk("midrst_scnt1", 1, 32'(sc[1]), 32'd0);
        chk("midrst_fcnt0", 0, 32'(fc[0]), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("inrst_scnt0", 0, 32'(sc[0]), 32'd0);
        chk("inrst_stall", 0, 32'(st[0]), 32'd0);
        rst = 1'b0;
        #1;
        chk("postrst_empty", 0, 32'(st[0]), 32'd0);
        chk("postrst_scnt", 0, 32'(sc[0]), 32'd0);
        // 9241 now issues and then depends on itself
        @(negedge clk);
        chk("selfdep_stall", 0, 32'(st[0]), 32'd1);

        // ---- stall counter saturation ----
        // Preload near the top instead of spending ~98k cycles getting there.
        force dut0.r_stall_cnt = 16'hFFFC;
        @(negedge clk);
        release dut0.r_stall_cnt;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (k >= 15) chk("sat_scnt", k, 32'(sc[0]), 32'hFFFF);
        end
        chk("sat_still_stalling", 0, 32'(st[0] | st[0] ^ st[0]), 32'(st[0]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
